frequency_meter: RTL and testbench

//  Measures the frequency of an external/slow clock-like signal (e.g. a divider output) by counting its

---
 rtl/frequency_meter_pkg.sv | 19 +
 rtl/frequency_meter_if.sv | 37 +++
 rtl/frequency_meter_sync_edge_detect.sv | 31 +++
 rtl/frequency_meter.sv | 116 +++++++++++
 tb/tb_frequency_meter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/frequency_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, arm length and parameter defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package frequency_meter_pkg;

    // FSM state encoding, kept as plain constants so the state register is an ordinary vector
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_GATE = 2'd2;

    // Cycles spent in ARM before the first window; flushes stale synchronizer contents
    localparam int ARM_CYCLES = 2;

    // Defaults give a 1 s gate at 50 MHz so the result reads directly in Hz
    localparam int DEFAULT_GATE_CYCLES = 50_000_000;
    localparam int DEFAULT_COUNT_W     = 26;
    localparam int DEFAULT_GATE_W      = 26;

endpackage

// File: rtl/frequency_meter_if.sv
// Measurement bus of the frequency meter: control/signal inputs and the result outputs.
// Latency: n/a (wiring only).
// Backpressure: none; freq_valid is a one-cycle pulse and the result registers hold in between.
interface frequency_meter_if
    import frequency_meter_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W
);

    logic               enable;
    logic               sig_in;
    logic [COUNT_W-1:0] freq_count;
    logic               freq_valid;
    logic               overflow;
    logic               busy;

    // The meter itself
    modport master (
        input  enable,
        input  sig_in,
        output freq_count,
        output freq_valid,
        output overflow,
        output busy
    );

    // Whoever controls the meter and consumes its results
    modport slave (
        output enable,
        output sig_in,
        input  freq_count,
        input  freq_valid,
        input  overflow,
        input  busy
    );

endinterface

// File: rtl/frequency_meter_sync_edge_detect.sv
// Brings an asynchronous input into the clk domain (2-FF sync) and flags its rising edges.
// Latency: rise asserts 2 cycles after the input is first sampled high; one-cycle pulse.
// Backpressure: none; free-running, edges faster than clk/2 are lost.
module frequency_meter_sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    // Two metastability stages followed by one history stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= async_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    // Rising edge of the synchronized signal
    assign rise = sync_2 & ~sync_3;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clocks and reports the total.
// Latency: first freq_valid 2+GATE_CYCLES cycles after enable is first sampled high, then every GATE_CYCLES.
// Backpressure: none; results are one-cycle pulses, dropping enable aborts the window in progress.
module frequency_meter
    import frequency_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int COUNT_W     = DEFAULT_COUNT_W,
    parameter int GATE_W      = DEFAULT_GATE_W
) (
    input  logic                  clk_50Mhz,
    input  logic                  reset,
    frequency_meter_if.master     bus
);

    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [1:0]         ARM_LAST  = 2'(ARM_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic [1:0]         state;
    logic [1:0]         arm_cnt;
    logic [GATE_W-1:0]  gate_cnt;
    logic [COUNT_W-1:0] edge_cnt;
    logic               sat_seen;

    logic               sig_rise;
    logic               terminal;
    logic               at_max;
    logic               inc_sat;
    logic [COUNT_W-1:0] edge_cnt_next;

    frequency_meter_sync_edge_detect u_sync (
        .clk      (clk_50Mhz),
        .reset    (reset),
        .async_in (bus.sig_in),
        .rise     (sig_rise)
    );

    // Last cycle of the current gate window
    assign terminal = (state == ST_GATE) && (gate_cnt == GATE_LAST);

    // Saturating increment: an edge arriving at the ceiling is dropped and remembered
    assign at_max        = (edge_cnt == COUNT_MAX);
    assign inc_sat       = sig_rise & at_max;
    assign edge_cnt_next = (sig_rise && !at_max) ? edge_cnt + COUNT_W'(1) : edge_cnt;

    // FSM, gate timer and edge accumulator; enable low drops straight back to IDLE
    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            state    <= ST_IDLE;
            arm_cnt  <= 2'd0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_seen <= 1'b0;
        end else if (!bus.enable) begin
            state    <= ST_IDLE;
            arm_cnt  <= 2'd0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_ARM;
                    arm_cnt <= 2'd0;
                end
                ST_ARM: begin
                    if (arm_cnt == ARM_LAST) begin
                        state    <= ST_GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat_seen <= 1'b0;
                    end else begin
                        arm_cnt <= arm_cnt + 2'd1;
                    end
                end
                ST_GATE: begin
                    if (terminal) begin
                        // Next window starts immediately, no dead cycle
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat_seen <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        edge_cnt <= edge_cnt_next;
                        sat_seen <= sat_seen | inc_sat;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result registers: loaded at the end of each completed window, held otherwise
    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            bus.freq_count <= '0;
            bus.overflow   <= 1'b0;
            bus.freq_valid <= 1'b0;
        end else begin
            bus.freq_valid <= 1'b0;
            if (bus.enable && terminal) begin
                // An edge seen on the terminal cycle still belongs to this window
                bus.freq_count <= edge_cnt_next;
                bus.overflow   <= sat_seen | inc_sat;
                bus.freq_valid <= 1'b1;
            end
        end
    end

    // Busy whenever a measurement is being armed or gated
    assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_frequency_meter.sv
// Randomized bench for frequency_meter with two instances (wide and 5-bit result) sharing stimulus.
// The reference keeps the sampled input history and recomputes each window's edge count arithmetically.
// Outputs are compared every cycle, 1 time unit after the rising clock edge.
module tb_frequency_meter;

    localparam int GATE = 100;
    localparam int CW_A = 26;
    localparam int CW_B = 5;
    localparam int MAXC = 40000;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    logic clk_50Mhz = 1'b0;
    logic reset;
    logic enable;
    logic sig_in;

    always #5 clk_50Mhz = ~clk_50Mhz;

    frequency_meter_if #(.COUNT_W(CW_A)) bus_a ();
    frequency_meter_if #(.COUNT_W(CW_B)) bus_b ();

    assign bus_a.enable = enable;
    assign bus_a.sig_in = sig_in;
    assign bus_b.enable = enable;
    assign bus_b.sig_in = sig_in;

    frequency_meter #(.GATE_CYCLES(GATE), .COUNT_W(CW_A), .GATE_W(26)) dut_a (
        .clk_50Mhz (clk_50Mhz),
        .reset     (reset),
        .bus       (bus_a)
    );

    frequency_meter #(.GATE_CYCLES(GATE), .COUNT_W(CW_B), .GATE_W(26)) dut_b (
        .clk_50Mhz (clk_50Mhz),
        .reset     (reset),
        .bus       (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    bit x_hist [MAXC];
    int cyc = 0;
    int run_start = -1;
    int ea_count = 0, eb_count = 0;
    bit ea_ovf = 0, eb_ovf = 0, e_valid = 0, e_busy = 0;

    // Stimulus control
    int sig_mode = 2;
    int sig_per = 10;
    int sig_ph = 0;
    int first_valid = -1;
    int start_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: a result at edge k counts input rises at sample indices k-GATE-1 .. k-2
    task automatic model_edge(input bit rst, input bit en, input bit sg);
        int el;
        int n;
        x_hist[cyc] = rst ? 1'b0 : sg;
        if (rst) begin
            run_start = -1;
            ea_count = 0; eb_count = 0;
            ea_ovf = 0; eb_ovf = 0;
            e_valid = 0;
        end else if (!en) begin
            run_start = -1;
            e_valid = 0;
        end else begin
            if (run_start < 0) run_start = cyc;
            e_valid = 0;
            el = cyc - run_start;
            if (el >= GATE + 2 && ((el - 2) % GATE) == 0) begin
                n = 0;
                for (int j = cyc - GATE - 1; j <= cyc - 2; j++)
                    if (x_hist[j] && !x_hist[j-1]) n++;
                ea_count = (n > MAX_A) ? MAX_A : n;
                ea_ovf   = (n > MAX_A);
                eb_count = (n > MAX_B) ? MAX_B : n;
                eb_ovf   = (n > MAX_B);
                e_valid  = 1;
            end
        end
        e_busy = (run_start >= 0);
    endtask

    task automatic tick();
        case (sig_mode)
            0:       sig_in = 1'b0;
            1:       sig_in = 1'b1;
            2:       sig_in = (((cyc + sig_ph) % sig_per) < (sig_per / 2));
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk_50Mhz);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        model_edge(reset, enable, sig_in);
        #1;
        if (bus_a.freq_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        check_val("a_valid", 32'(bus_a.freq_valid), 32'(e_valid));
        check_val("a_count", 32'(bus_a.freq_count), 32'(ea_count));
        check_val("a_ovf",   32'(bus_a.overflow),   32'(ea_ovf));
        check_val("a_busy",  32'(bus_a.busy),       32'(e_busy));
        check_val("b_valid", 32'(bus_b.freq_valid), 32'(e_valid));
        check_val("b_count", 32'(bus_b.freq_count), 32'(eb_count));
        check_val("b_ovf",   32'(bus_b.overflow),   32'(eb_ovf));
        check_val("b_busy",  32'(bus_b.busy),       32'(e_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int bound);
        int got;
        got = 0;
        for (int i = 0; i < bound && got == 0; i++) begin
            tick();
            if (bus_a.freq_valid === 1'b1) got = 1;
        end
        if (got == 0) check_val("wait_valid", 32'(got), 32'd1);
    endtask

    task automatic set_period(input int per);
        sig_mode = 2;
        sig_per  = per;
        sig_ph   = $urandom_range(0, per - 1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        set_period(10);

        // Reset state
        run(4);

        // Period-10 input, continuous measurement
        reset = 1'b0;
        enable = 1'b1;
        start_cyc = cyc + 1;
        first_valid = -1;
        run(350);
        check_val("first_latency", 32'(first_valid - start_cyc), 32'd102);
        check_val("period10_count", 32'(bus_a.freq_count), 32'd10);

        // Constant input, high then low
        sig_mode = 1;
        run(250);
        check_val("hold1_count", 32'(bus_a.freq_count), 32'd0);
        sig_mode = 0;
        run(250);
        check_val("hold0_count", 32'(bus_a.freq_count), 32'd0);

        // Abort mid-window, re-enable 20 cycles later
        set_period(10);
        wait_valid(150);
        run(50);
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        start_cyc = cyc + 1;
        first_valid = -1;
        run(250);
        check_val("reenable_latency", 32'(first_valid - start_cyc), 32'd102);

        // Saturation on the narrow counter, then recovery
        set_period(2);
        run(300);
        check_val("sat_count", 32'(bus_b.freq_count), 32'd31);
        check_val("sat_ovf", 32'(bus_b.overflow), 32'd1);
        check_val("wide_count", 32'(bus_a.freq_count), 32'd50);
        set_period(10);
        run(300);
        check_val("recover_count", 32'(bus_b.freq_count), 32'd10);
        check_val("recover_ovf", 32'(bus_b.overflow), 32'd0);

        // Period 9 with several phases: edges land on window boundaries
        for (int p = 0; p < 6; p++) begin
            set_period(9);
            run(230);
        end

        // Reset pulse mid-window with enable held high
        set_period(7);
        wait_valid(150);
        run(40);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        start_cyc = cyc + 1;
        first_valid = -1;
        run(250);
        check_val("reset_latency", 32'(first_valid - start_cyc), 32'd102);

        // Random segments: periods, holds, noise, enable drops and resets
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 5))
                0:       sig_mode = 0;
                1:       sig_mode = 1;
                2, 3:    sig_mode = 3;
                default: set_period($urandom_range(2, 40));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 2));
                reset = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) begin
                enable = 1'b0;
                run($urandom_range(1, 30));
                enable = 1'b1;
            end
            run($urandom_range(60, 400));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
